// File: rtl/data_bus_bridge_pkg.sv
// Shared types and constants for the MEM-stage data bus bridge.
// Bridge FSM encodings, bus command bundle and small helpers.
package data_bus_bridge_pkg;

  localparam int BUS_TIMEOUT_DEFAULT = 255;
  localparam int MEM_STALL_BIT       = 4;

  typedef enum logic [1:0] {
    BRIDGE_IDLE = 2'd0,
    BRIDGE_BUSY = 2'd1,
    BRIDGE_DONE = 2'd2
  } bridge_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_cmd_t;

  function automatic bus_cmd_t make_cmd(
    input logic        we,
    input logic [31:0] addr,
    input logic [3:0]  sel,
    input logic [31:0] wdata
  );
    bus_cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.sel   = sel;
    c.wdata = wdata;
    return c;
  endfunction

  // Only a live load hands data back; stores and flushed loads return zero.
  function automatic logic [31:0] load_result(
    input logic        is_load,
    input logic        killed,
    input logic [31:0] rdata
  );
    return (is_load && !killed) ? rdata : 32'd0;
  endfunction

endpackage

// File: rtl/data_bus_bridge_watchdog.sv
// Saturating BUSY-cycle counter for the data bus bridge.
// Flags expiry on the last permitted cycle without an ack.
module data_bus_bridge_watchdog #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/data_bus_bridge.sv
// MEM-stage to data bus bridge: single-cycle request to req/ack.
// Stalls the pipeline until completion; tolerates flushes and hangs.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_timeout_o
);

  bridge_state_t state;
  bus_cmd_t      cmd_q;
  logic [31:0]   rd_buf;
  logic          aborted;
  logic          accept;
  logic          abort_now;
  logic          wd_clear;
  logic          wd_en;
  logic          wd_expired;
  logic          mem_held;
  logic          unused_stall;

  assign accept    = (state == BRIDGE_IDLE) && mem_ce_i &&
                     (|mem_sel_i) && !flush_i;
  assign abort_now = aborted || flush_i;
  assign mem_held  = stall_i[MEM_STALL_BIT];
  assign wd_clear  = accept;
  assign wd_en     = (state == BRIDGE_BUSY);

  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  data_bus_bridge_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign bus_we_o    = cmd_q.we;
  assign bus_addr_o  = cmd_q.addr;
  assign bus_sel_o   = cmd_q.sel;
  assign bus_wdata_o = cmd_q.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BRIDGE_IDLE;
      cmd_q         <= '0;
      bus_req_o     <= 1'b0;
      rd_buf        <= '0;
      aborted       <= 1'b0;
      bus_timeout_o <= 1'b0;
    end else begin
      bus_timeout_o <= 1'b0;
      unique case (state)
        BRIDGE_IDLE: begin
          if (accept) begin
            cmd_q     <= make_cmd(mem_we_i, mem_addr_i,
                                  mem_sel_i, mem_data_i);
            bus_req_o <= 1'b1;
            aborted   <= 1'b0;
            state     <= BRIDGE_BUSY;
          end
        end
        BRIDGE_BUSY: begin
          if (flush_i) begin
            aborted <= 1'b1;
          end
          // An ack landing on the expiry cycle still completes normally.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            cmd_q.we  <= 1'b0;
            cmd_q.sel <= '0;
            rd_buf    <= load_result(!cmd_q.we, abort_now,
                                     bus_rdata_i);
            state     <= abort_now ? BRIDGE_IDLE : BRIDGE_DONE;
          end else if (wd_expired) begin
            bus_req_o     <= 1'b0;
            cmd_q.we      <= 1'b0;
            cmd_q.sel     <= '0;
            rd_buf        <= '0;
            bus_timeout_o <= 1'b1;
            state         <= abort_now ? BRIDGE_IDLE : BRIDGE_DONE;
          end
        end
        BRIDGE_DONE: begin
          // Hold the result while MEM is stalled so nothing reissues.
          if (flush_i || !mem_held) begin
            state <= BRIDGE_IDLE;
          end
        end
        default: begin
          state <= BRIDGE_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    mem_data_o = '0;
    unique case (state)
      BRIDGE_IDLE: stallreq_o = accept;
      BRIDGE_BUSY: stallreq_o = !abort_now;
      BRIDGE_DONE: mem_data_o = rd_buf;
      default:     stallreq_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: directed table, random transactions
// against a transaction-level model, and reset/flush sequences.
module tb_data_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] mem_data_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_timeout_o;

  always #5 clk = ~clk;

  data_bus_bridge #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_ce_i      (mem_ce_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_sel_i     (mem_sel_i),
    .mem_data_i    (mem_data_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .mem_data_o    (mem_data_o),
    .stallreq_o    (stallreq_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_sel_o     (bus_sel_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_timeout_o (bus_timeout_o)
  );

  // d: BUSY cycles before ack, f: BUSY cycle of flush (-1 none),
  // h: extra DONE cycles with MEM held.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;
    int          f;
    int          h;
    int          e_req;
    int          e_stall;
    int          e_to;
    logic [31:0] e_data;
  } vec_t;

  int vecs = 0;
  int miss = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [31:0] addr, input logic [3:0] sel,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input int d, input int f, input int h,
    input int e_req, input int e_stall, input int e_to,
    input logic [31:0] e_data);
    vec_t v;
    v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.rdata = rdata; v.d = d; v.f = f; v.h = h;
    v.e_req = e_req; v.e_stall = e_stall; v.e_to = e_to;
    v.e_data = e_data;
    return v;
  endfunction

  // Transaction-level reference: outcome from ack delay, flush point
  // and the timeout budget.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   last;
    bit   ab;
    bit   to;
    r = v;
    if (v.sel == 4'd0) begin
      r.e_req = 0; r.e_stall = 0; r.e_to = 0; r.e_data = 32'd0;
      return r;
    end
    last = (v.d < TO - 1) ? v.d : TO - 1;
    to = (v.d > TO - 1);
    ab = (v.f >= 0) && (v.f <= last);
    r.e_req = last + 1;
    r.e_stall = ab ? v.f : last + 1;
    r.e_to = to ? 1 : 0;
    r.e_data = (ab || to || v.we) ? 32'd0 : v.rdata;
    return r;
  endfunction

  task automatic idle_inputs();
    mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_sel_i = 0;
    mem_data_i = 0; stall_i = 0; flush_i = 0;
    bus_ack_i = 0; bus_rdata_i = 0;
  endtask

  task automatic run(input vec_t v, input string nm);
    int req_n = 0;
    int stall_n = 0;
    int to_n = 0;
    int bad = 0;
    int post_bad = 0;
    bit flushed = 0;
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = v.we; mem_addr_i = v.addr;
    mem_sel_i = v.sel; mem_data_i = v.wdata;
    stall_i = 6'b010000; flush_i = 0; bus_ack_i = 0;
    bus_rdata_i = $urandom;
    #1;
    check($sformatf("%s.issue", nm), {30'd0, bus_req_o, stallreq_o},
          {30'd0, 1'b0, v.sel != 4'd0});
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == v.f) flushed = 1;
      flush_i = (k == v.f);
      bus_ack_i = (k == v.d);
      bus_rdata_i = (k == v.d) ? v.rdata : $urandom;
      mem_ce_i = !flushed;
      mem_we_i = 1'($urandom);
      mem_addr_i = $urandom;
      mem_data_i = $urandom;
      mem_sel_i = (v.sel == 4'd0) ? 4'd0 : 4'($urandom_range(1, 15));
      stall_i = 6'b010000;
      #1;
      to_n += int'(bus_timeout_o);
      if (!bus_req_o) break;
      req_n++;
      if (stallreq_o) stall_n++;
      if (bus_addr_o !== v.addr || bus_we_o !== v.we ||
          bus_sel_o !== v.sel || bus_wdata_o !== v.wdata ||
          mem_data_o !== 32'd0) bad++;
    end
    if (mem_data_o !== v.e_data || stallreq_o !== 1'b0) post_bad++;
    for (int j = 1; j <= v.h + 1; j++) begin
      @(negedge clk);
      flush_i = 0; bus_ack_i = 0;
      mem_ce_i = !flushed;
      mem_addr_i = $urandom;
      mem_sel_i = (v.sel == 4'd0) ? 4'd0 : 4'($urandom_range(1, 15));
      stall_i = (j <= v.h) ? 6'b010000 : 6'b101111;
      #1;
      to_n += int'(bus_timeout_o);
      if (mem_data_o !== v.e_data || stallreq_o || bus_req_o)
        post_bad++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check($sformatf("%s.req_cycles", nm), req_n, v.e_req);
    check($sformatf("%s.stall_cycles", nm), stall_n, v.e_stall);
    check($sformatf("%s.timeouts", nm), to_n, v.e_to);
    check($sformatf("%s.bus_hold", nm), bad, 0);
    check($sformatf("%s.result", nm), post_bad, 0);
    check($sformatf("%s.idle_data", nm), mem_data_o, 32'd0);
    check($sformatf("%s.idle_ctl", nm),
          {29'd0, bus_req_o, stallreq_o, bus_timeout_o}, 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int   d;
    int   last;

    tbl[0] = mk(0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF,
                3, -1, 0, 4, 4, 0, 32'hDEADBEEF);
    tbl[1] = mk(1, 32'h103, 4'b0001, 32'h5A5A5A5A, 32'h11111111,
                0, -1, 0, 1, 1, 0, 32'h0);
    tbl[2] = mk(1, 32'h200, 4'b0000, 32'h77777777, 32'h0,
                99, -1, 0, 0, 0, 0, 32'h0);
    tbl[3] = mk(0, 32'h300, 4'hF, 32'h0, 32'h12345678,
                3, 1, 0, 4, 1, 0, 32'h0);
    tbl[4] = mk(0, 32'h400, 4'hF, 32'h0, 32'h99999999,
                99, -1, 0, 4, 4, 1, 32'h0);
    tbl[5] = mk(0, 32'h500, 4'hF, 32'h0, 32'hCAFEF00D,
                1, -1, 3, 2, 2, 0, 32'hCAFEF00D);
    tbl[6] = mk(0, 32'h600, 4'b1100, 32'h0, 32'h55AA55AA,
                99, 2, 0, 4, 2, 1, 32'h0);
    tbl[7] = mk(0, 32'h700, 4'hF, 32'h0, 32'h13579BDF,
                2, 2, 1, 3, 2, 0, 32'h0);

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.data", mem_data_o | bus_addr_o | bus_wdata_o, 32'd0);
    check("reset.ctl", {25'd0, bus_req_o, bus_we_o, bus_sel_o,
          stallreq_o, bus_timeout_o}, 32'd0);
    rst = 0;

    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom);
      v.addr = $urandom;
      v.sel = ($urandom_range(0, 9) == 0) ? 4'd0
              : 4'($urandom_range(1, 15));
      v.wdata = $urandom;
      v.rdata = $urandom;
      d = $urandom_range(0, 6);
      last = (d < TO - 1) ? d : TO - 1;
      v.d = d;
      v.f = ($urandom_range(0, 2) == 0) ? $urandom_range(0, last) : -1;
      v.h = $urandom_range(0, 3);
      if (v.sel == 4'd0) begin
        v.d = 99;
        v.f = -1;
      end
      run(model(v), $sformatf("rnd%0d", i));
    end

    // Synchronous reset in the middle of a transaction.
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'hAAAA0000;
    mem_sel_i = 4'hF; mem_data_i = 32'hFEEDFACE; stall_i = 6'b010000;
    repeat (2) @(negedge clk);
    mem_ce_i = 0;
    rst = 1;
    @(negedge clk);
    #1;
    check("rst_busy.data", mem_data_o | bus_addr_o | bus_wdata_o, 32'd0);
    check("rst_busy.ctl", {25'd0, bus_req_o, bus_we_o, bus_sel_o,
          stallreq_o, bus_timeout_o}, 32'd0);
    rst = 0;
    idle_inputs();

    // Flush while the result is parked in DONE drops it immediately.
    @(negedge clk);
    mem_ce_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h800;
    stall_i = 6'b010000;
    @(negedge clk);
    bus_ack_i = 1; bus_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    bus_ack_i = 0; bus_rdata_i = 0;
    #1;
    check("done_flush.before", mem_data_o, 32'h0BADF00D);
    @(negedge clk);
    flush_i = 1; mem_ce_i = 0;
    #1;
    check("done_flush.same", mem_data_o, 32'h0BADF00D);
    @(negedge clk);
    flush_i = 0;
    #1;
    check("done_flush.after", {mem_data_o[30:0], bus_req_o}, 32'd0);

    // Flush in IDLE suppresses a new access.
    @(negedge clk);
    mem_ce_i = 1; mem_sel_i = 4'hF; flush_i = 1; stall_i = 0;
    #1;
    check("idle_flush.stall", {31'd0, stallreq_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("idle_flush.req", {31'd0, bus_req_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
